// File: rtl/mux8_scan_ctrl_pkg.sv
// Shared constants and types for the 8:1 mux scan controller.
// Optional feature macro used elsewhere in this block: MUX8_SCAN_PARITY_EN.
package mux_scan_pkg;

    // Number of mux channels and width of the select bus.
    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_e;

    // Dwell counter width: ceil(log2(dwell)) bits, never narrower than 1 bit.
    function automatic int cnt_width(input int dwell);
        return (dwell <= 2) ? 1 : $clog2(dwell);
    endfunction

endpackage

// File: rtl/mux8_scan_ctrl_if.sv
// Mux-side and downstream-side signals of the scan controller, bundled.
// The slave modport is the controller's view; the master modport is the
// view of whatever surrounds it (mux plus downstream consumer).
// PARITY exists only when MUX8_SCAN_PARITY_EN is defined.
interface mux8_scan_ctrl_if;
    import mux_scan_pkg::*;

    logic              START;
    logic              READY;
    logic              Y;
    logic              S0;
    logic              S1;
    logic              S2;
    logic              BUSY;
    logic              VALID;
    logic [NUM_CH-1:0] DATA;
`ifdef MUX8_SCAN_PARITY_EN
    logic              PARITY;

    modport slave (
        input  START, READY, Y,
        output S0, S1, S2, BUSY, VALID, DATA, PARITY
    );

    modport master (
        output START, READY, Y,
        input  S0, S1, S2, BUSY, VALID, DATA, PARITY
    );
`else
    modport slave (
        input  START, READY, Y,
        output S0, S1, S2, BUSY, VALID, DATA
    );

    modport master (
        output START, READY, Y,
        input  S0, S1, S2, BUSY, VALID, DATA
    );
`endif

endinterface

// File: rtl/mux8_scan_ctrl_dwell_cnt.sv
// Dwell timer: counts cycles while enabled and raises expire_o on the
// cycle where the count equals DWELL-1, then wraps to zero on that edge.
// DWELL must lie in 1..255; 0 is not a legal setting.
module mux_scan_dwell_cnt
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int               CNT_W = cnt_width(DWELL);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Expiry is a pure decode of the current count, gated by enable.
    assign expire_o = en_i && (cnt_q == LAST);

    // Next count: clear wins, expiry wraps, otherwise advance when enabled.
    always_comb begin
        // NOTE: default assignment first so no path leaves cnt_d unassigned (no latch).
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (expire_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mux8_scan_ctrl.sv
// Scan sequencer for an external 8:1 mux. Walks the select lines through
// channels 0..7, holding each for DWELL cycles, samples Y into a shadow
// byte and presents the finished byte with a VALID/READY handshake.
// Define MUX8_SCAN_PARITY_EN to add a registered even-parity output.
module mux8_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 2
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    mux8_scan_ctrl_if.slave        bus
);

    state_e            state_q;
    logic [SEL_W-1:0]  sel_q;
    logic              busy_q;
    logic              valid_q;
    logic [NUM_CH-1:0] shadow_q;
    logic [NUM_CH-1:0] shadow_d;
    logic [NUM_CH-1:0] data_q;
    logic              expire;
`ifdef MUX8_SCAN_PARITY_EN
    logic              parity_q;
`endif

    // Dwell timer runs only in SCAN and is held at zero everywhere else,
    // so every scan starts counting from zero on the edge after START.
    mux_scan_dwell_cnt #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk      (CLK),
        .rst_n    (RST_N),
        .clr_i    (state_q != SCAN),
        .en_i     (state_q == SCAN),
        .expire_o (expire)
    );

    // Shadow byte with the current channel's sample merged in; used both to
    // update the shadow and to load DATA on the final channel in one edge.
    always_comb begin
        shadow_d = shadow_q;
        if (expire) begin
            shadow_d[sel_q] = bus.Y;
        end
    end

    // Controller FSM with registered select, busy, valid and data outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            // NOTE: the shadow byte is fully rewritten each scan, but it is
            // reset anyway so a scan aborted by reset leaves no stale bits.
            shadow_q <= '0;
            data_q   <= '0;
`ifdef MUX8_SCAN_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.START) begin
                        state_q <= SCAN;
                        sel_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end

                SCAN: begin
                    // START and READY are deliberately not looked at here.
                    if (expire) begin
                        shadow_q <= shadow_d;
                        if (sel_q == SEL_W'(NUM_CH - 1)) begin
                            state_q  <= HOLD;
                            sel_q    <= '0;
                            busy_q   <= 1'b0;
                            valid_q  <= 1'b1;
                            data_q   <= shadow_d;
`ifdef MUX8_SCAN_PARITY_EN
                            parity_q <= ^shadow_d;
`endif
                        end else begin
                            sel_q <= sel_q + 1'b1;
                        end
                    end
                end

                HOLD: begin
                    // Word transfers on the first edge with READY high.
                    if (bus.READY) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    sel_q   <= '0;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Drive the bus straight from registers.
    assign bus.S0    = sel_q[0];
    assign bus.S1    = sel_q[1];
    assign bus.S2    = sel_q[2];
    assign bus.BUSY  = busy_q;
    assign bus.VALID = valid_q;
    assign bus.DATA  = data_q;
`ifdef MUX8_SCAN_PARITY_EN
    assign bus.PARITY = parity_q;
`endif

endmodule

// File: tb/tb_mux8_scan_ctrl.sv
// Bench for mux8_scan_ctrl: two instances (DWELL = 1 and DWELL = 3), each
// with its own behavioural 8:1 mux. The expected word is built from the
// mux input values present at each channel's sampling edge.
// Honours MUX8_SCAN_PARITY_EN when it is defined for the build.
module tb_mux8_scan_ctrl;

    localparam int D0 = 1;
    localparam int D1 = 3;

    logic       CLK   = 1'b0;
    logic       RST_N = 1'b1;
    logic [7:0] mux_in [2];
    logic       start  [2];
    logic       ready  [2];

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int scan_id = 0;

    always #5 CLK = ~CLK;

    mux8_scan_ctrl_if if0 ();
    mux8_scan_ctrl_if if1 ();

    // External muxes and stimulus wiring.
    assign if0.START = start[0];
    assign if0.READY = ready[0];
    assign if0.Y     = mux_in[0][{if0.S2, if0.S1, if0.S0}];
    assign if1.START = start[1];
    assign if1.READY = ready[1];
    assign if1.Y     = mux_in[1][{if1.S2, if1.S1, if1.S0}];

    mux8_scan_ctrl #(.DWELL(D0)) u_dut0 (.CLK(CLK), .RST_N(RST_N), .bus(if0));
    mux8_scan_ctrl #(.DWELL(D1)) u_dut1 (.CLK(CLK), .RST_N(RST_N), .bus(if1));

    function automatic int dwell_of(input int u);
        return (u == 0) ? D0 : D1;
    endfunction

    function automatic logic [2:0] sel_of(input int u);
        return (u == 0) ? {if0.S2, if0.S1, if0.S0} : {if1.S2, if1.S1, if1.S0};
    endfunction

    function automatic logic busy_of(input int u);
        return (u == 0) ? if0.BUSY : if1.BUSY;
    endfunction

    function automatic logic valid_of(input int u);
        return (u == 0) ? if0.VALID : if1.VALID;
    endfunction

    function automatic logic [7:0] data_of(input int u);
        return (u == 0) ? if0.DATA : if1.DATA;
    endfunction

`ifdef MUX8_SCAN_PARITY_EN
    function automatic logic parity_of(input int u);
        return (u == 0) ? if0.PARITY : if1.PARITY;
    endfunction
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    // All outputs at their reset values.
    task automatic reset_check(input int u, input string tag);
        check({tag, " sel"},   32'(sel_of(u)),   32'd0);
        check({tag, " busy"},  32'(busy_of(u)),  32'd0);
        check({tag, " valid"}, 32'(valid_of(u)), 32'd0);
        check({tag, " data"},  32'(data_of(u)),  32'd0);
`ifdef MUX8_SCAN_PARITY_EN
        check({tag, " parity"}, 32'(parity_of(u)), 32'd0);
`endif
    endtask

    // One complete scan plus handshake on instance u. Called at a negedge
    // with the instance in IDLE; returns at a negedge with it back in IDLE.
    //   keep_start : START stays high and READY stays high (back-to-back mode)
    //   hold_cycles: edges spent in HOLD with READY low before READY rises
    //   poke_start : toggle START randomly while waiting in HOLD
    //   flip_ch    : invert mux input flip_ch right after its sample (-1: none)
    //   rnd_chg    : randomly rewrite the mux inputs during the scan
    task automatic do_scan(input int u, input bit keep_start, input int hold_cycles,
                           input bit poke_start, input int flip_ch, input bit rnd_chg);
        int         d;
        int         ch;
        logic [7:0] exp_w;
        string      tag;
        d     = dwell_of(u);
        exp_w = '0;
        scan_id++;
        start[u] = 1'b1;
        ready[u] = keep_start;
        step();                                    // edge E0 has sampled START
        if (!keep_start) start[u] = 1'b0;
        for (int t = 0; t < 8 * d; t++) begin
            // After edge E0+t the select shows the channel in progress.
            tag = $sformatf("scan%0d u%0d t%0d", scan_id, u, t);
            check({tag, " sel"},   32'(sel_of(u)),   32'(t / d));
            check({tag, " busy"},  32'(busy_of(u)),  32'd1);
            check({tag, " valid"}, 32'(valid_of(u)), 32'd0);
            if (!keep_start) ready[u] = 1'($urandom_range(1));
            if (rnd_chg && $urandom_range(3) == 0) mux_in[u] = 8'($urandom);
            if (flip_ch >= 0 && t == (flip_ch + 1) * d)
                mux_in[u][flip_ch] = ~mux_in[u][flip_ch];
            // Channel ch is sampled at edge E0+(ch+1)*d, the next edge here.
            if ((t + 1) % d == 0) begin
                ch = (t + 1) / d - 1;
                exp_w[ch] = mux_in[u][ch];
            end
            step();
        end
        tag = $sformatf("scan%0d u%0d hold", scan_id, u);
        check({tag, " valid"}, 32'(valid_of(u)), 32'd1);
        check({tag, " busy"},  32'(busy_of(u)),  32'd0);
        check({tag, " sel"},   32'(sel_of(u)),   32'd0);
        check({tag, " data"},  32'(data_of(u)),  32'(exp_w));
`ifdef MUX8_SCAN_PARITY_EN
        check({tag, " parity"}, 32'(parity_of(u)), 32'(^exp_w));
`endif
        for (int i = 0; i < hold_cycles; i++) begin
            ready[u] = 1'b0;
            start[u] = poke_start ? 1'($urandom_range(1)) : 1'b0;
            step();
            tag = $sformatf("scan%0d u%0d wait%0d", scan_id, u, i);
            check({tag, " valid"}, 32'(valid_of(u)), 32'd1);
            check({tag, " busy"},  32'(busy_of(u)),  32'd0);
            check({tag, " data"},  32'(data_of(u)),  32'(exp_w));
        end
        ready[u] = 1'b1;
        start[u] = keep_start;
        step();                                    // transfer edge
        tag = $sformatf("scan%0d u%0d done", scan_id, u);
        check({tag, " valid"}, 32'(valid_of(u)), 32'd0);
        check({tag, " busy"},  32'(busy_of(u)),  32'd0);
        check({tag, " sel"},   32'(sel_of(u)),   32'd0);
        check({tag, " data"},  32'(data_of(u)),  32'(exp_w));
        ready[u] = keep_start;
    endtask

    initial begin
        int u;
        start[0]  = 1'b0;
        start[1]  = 1'b0;
        ready[0]  = 1'b0;
        ready[1]  = 1'b0;
        mux_in[0] = 8'b1010_1010;
        mux_in[1] = 8'h01;

        // Reset state.
        #1 RST_N = 1'b0;
        step();
        reset_check(0, "rst u0");
        reset_check(1, "rst u1");
        RST_N = 1'b1;
        step();
        step();
        reset_check(0, "post-rst u0");

        // DWELL = 1, pattern AA, brief wait in HOLD.
        do_scan(0, 1'b0, 2, 1'b0, -1, 1'b0);

        // DWELL = 3, pattern 01, READY low 10 cycles with START pokes.
        do_scan(1, 1'b0, 10, 1'b1, -1, 1'b0);

        // Channel 3 input changes right after it was sampled.
        mux_in[1] = 8'h5C;
        do_scan(1, 1'b0, 1, 1'b0, 3, 1'b0);
        do_scan(1, 1'b0, 0, 1'b0, -1, 1'b0);

        // Randomized scans with mid-scan input changes.
        repeat (8) begin
            u = int'($urandom_range(1));
            mux_in[u] = 8'($urandom);
            do_scan(u, 1'b0, int'($urandom_range(4)), 1'b1, -1, 1'b1);
        end

        // START and READY held high: one IDLE cycle between words.
        mux_in[0] = 8'h3C;
        repeat (3) do_scan(0, 1'b1, 0, 1'b0, -1, 1'b0);
        start[0] = 1'b0;
        ready[0] = 1'b0;
        step();
        check("b2b end busy",  32'(busy_of(0)),  32'd0);
        check("b2b end valid", 32'(valid_of(0)), 32'd0);

        // Reset mid-scan while instance 1 shows select 5.
        mux_in[1] = 8'hFF;
        start[1] = 1'b1;
        step();
        start[1] = 1'b0;
        repeat (5 * D1) step();
        check("pre-abort sel", 32'(sel_of(1)), 32'd5);
        #2 RST_N = 1'b0;
        #1;
        reset_check(1, "abort u1");
        reset_check(0, "abort u0");
        step();
        RST_N = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            check($sformatf("after-abort %0d valid", i), 32'(valid_of(1)), 32'd0);
            check($sformatf("after-abort %0d busy", i),  32'(busy_of(1)),  32'd0);
        end

        // A fresh scan after the aborted one.
        mux_in[1] = 8'h96;
        do_scan(1, 1'b0, 1, 1'b0, -1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        if (n_pass + n_fail != n_chk) $fatal(1, "FAIL check bookkeeping");
        $finish;
    end

endmodule
